// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants and the digest writer state type.
package sha256_pkg;
   localparam int DIGEST_WIDTH     = 256;
   localparam int WORD_WIDTH       = 32;
   localparam int NUM_DIGEST_WORDS = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      DONE  = 2'd2
   } writer_state_e;
endpackage

// File: rtl/sha256_digest_writer.sv
// Writes a captured 256-bit SHA-256 digest as eight big-endian 32-bit words
// to the output SRAM, then pulses write_complete for one cycle.
module sha256_digest_writer #(
   parameter int ADDR_WIDTH = 12,
   parameter int WORD_WIDTH = 32
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic                             digest_valid,
   input  logic [sha256_pkg::DIGEST_WIDTH-1:0] digest,
   input  logic [ADDR_WIDTH-1:0]            base_address,
   input  logic                             mem_ready,
   output logic                             mem_write_enable,
   output logic [ADDR_WIDTH-1:0]            mem_address,
   output logic [WORD_WIDTH-1:0]            mem_write_data,
   output logic                             busy,
   output logic                             write_complete
);
   import sha256_pkg::*;

   localparam int IDX_W = $clog2(NUM_DIGEST_WORDS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGEST_WORDS - 1);

   writer_state_e           state_q, state_d;
   logic [IDX_W-1:0]        index_q, index_d;
   logic                    we_q, we_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [WORD_WIDTH-1:0]   data_q, data_d;
   logic                    complete_q, complete_d;
   logic [DIGEST_WIDTH-1:0] digest_q;
   logic [ADDR_WIDTH-1:0]   base_q;
   logic                    capture;
   logic [IDX_W-1:0]        next_index;
   logic [WORD_WIDTH-1:0]   next_word;

   assign next_index = index_q + 1'b1;

   // Word select for the word presented after the current one is accepted.
   always_comb begin
      next_word = '0;
      case (next_index)
         3'd0: next_word = digest_q[255:224];
         3'd1: next_word = digest_q[223:192];
         3'd2: next_word = digest_q[191:160];
         3'd3: next_word = digest_q[159:128];
         3'd4: next_word = digest_q[127:96];
         3'd5: next_word = digest_q[95:64];
         3'd6: next_word = digest_q[63:32];
         3'd7: next_word = digest_q[31:0];
         default: next_word = '0;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      index_d    = index_q;
      we_d       = we_q;
      addr_d     = addr_q;
      data_d     = data_q;
      complete_d = 1'b0;
      capture    = 1'b0;
      case (state_q)
         IDLE: begin
            if (digest_valid) begin
               // Word 0 comes straight from the inputs so it is on the bus next cycle.
               capture = 1'b1;
               state_d = WRITE;
               index_d = '0;
               we_d    = 1'b1;
               addr_d  = base_address;
               data_d  = digest[DIGEST_WIDTH-1 -: WORD_WIDTH];
            end
         end
         WRITE: begin
            if (we_q && mem_ready) begin
               if (index_q == LAST_IDX) begin
                  state_d    = DONE;
                  we_d       = 1'b0;
                  complete_d = 1'b1;
               end else begin
                  index_d = next_index;
                  addr_d  = base_q + ADDR_WIDTH'(next_index);
                  data_d  = next_word;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            index_d = '0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         index_q    <= '0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         complete_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         index_q    <= index_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         complete_q <= complete_d;
      end
   end

   always_ff @(posedge clock) begin
      if (capture) begin
         digest_q <= digest;
         base_q   <= base_address;
      end
   end

   assign mem_write_enable = we_q;
   assign mem_address      = addr_q;
   assign mem_write_data   = data_q;
   assign busy             = (state_q != IDLE);
   assign write_complete   = complete_q;
endmodule

// File: tb/tb_sha256_digest_writer.sv
// Self-checking bench for sha256_digest_writer against a transaction-level model.
module tb_sha256_digest_writer;
   localparam logic [255:0] ABC =
      256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
   localparam int MAXC = 128;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic         digest_valid = 1'b0;
   logic [255:0] digest = '0;
   logic [11:0]  base_address = '0;
   logic         mem_ready = 1'b1;
   logic         mem_write_enable;
   logic [11:0]  mem_address;
   logic [31:0]  mem_write_data;
   logic         busy;
   logic         write_complete;

   int passed = 0;
   int total  = 0;

   // {busy, write_complete, we, addr, data}; addr/data only meaningful when we=1
   logic [46:0] obs  [MAXC];
   logic [46:0] expv [MAXC];

   sha256_digest_writer #(.ADDR_WIDTH(12), .WORD_WIDTH(32)) dut (
      .clock            (clock),
      .reset            (reset),
      .digest_valid     (digest_valid),
      .digest           (digest),
      .base_address     (base_address),
      .mem_ready        (mem_ready),
      .mem_write_enable (mem_write_enable),
      .mem_address      (mem_address),
      .mem_write_data   (mem_write_data),
      .busy             (busy),
      .write_complete   (write_complete)
   );

   always #5 clock = ~clock;

   function automatic logic [255:0] rand_digest();
      logic [255:0] d;
      for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom;
      return d;
   endfunction

   // One digest transfer: word n goes to (b+n) mod 4096, one word per accepted cycle.
   task automatic model_txn(input int start, input logic [255:0] d, input logic [11:0] b,
                            input logic [MAXC-1:0] stall, output int idle_cyc);
      int c = start + 1;
      int n = 0;
      logic [11:0] a;
      while (n < 8 && c < MAXC - 1) begin
         a = 12'(int'(b) + n);
         expv[c] = {1'b1, 1'b0, 1'b1, a, d[255-32*n -: 32]};
         if (!stall[c]) n++;
         c++;
      end
      expv[c] = {1'b1, 1'b1, 1'b0, 12'h0, 32'h0};
      idle_cyc = c + 1;
   endtask

   task automatic model_run(input logic [255:0] d1, input logic [11:0] b1,
                            input logic [255:0] d2, input logic [11:0] b2,
                            input logic [MAXC-1:0] stall, input int pulse2, input int ncyc);
      int idle1, idle2;
      for (int c = 0; c < MAXC; c++) expv[c] = '0;
      model_txn(0, d1, b1, stall, idle1);
      if (pulse2 >= idle1 && pulse2 < ncyc) model_txn(pulse2, d2, b2, stall, idle2);
   endtask

   // Called just after a rising edge; cycle 0 is the digest_valid cycle.
   task automatic drive_txn(input logic [255:0] d1, input logic [11:0] b1,
                            input logic [255:0] d2, input logic [11:0] b2,
                            input logic [MAXC-1:0] stall, input int pulse2, input int ncyc);
      for (int c = 0; c < ncyc; c++) begin
         digest_valid = (c == 0) || (c == pulse2);
         digest       = (c == 0) ? d1 : d2;
         base_address = (c == 0) ? b1 : b2;
         mem_ready    = !stall[c];
         @(negedge clock);
         obs[c] = {busy, write_complete, mem_write_enable,
                   mem_write_enable ? mem_address : 12'h0,
                   mem_write_enable ? mem_write_data : 32'h0};
         @(posedge clock);
         #1;
      end
      digest_valid = 1'b0;
      mem_ready    = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      total++;
      if ({busy, write_complete, mem_write_enable, mem_address, mem_write_data} !== 47'h0)
         $display("FAIL reset_state got %h want 0",
                  {busy, write_complete, mem_write_enable, mem_address, mem_write_data});
      else passed++;
      reset = 1'b1;
      @(posedge clock);
      #1;
      total++;
      if ({busy, mem_write_enable, write_complete} !== 3'b000)
         $display("FAIL reset_release_idle got %b want 000",
                  {busy, mem_write_enable, write_complete});
      else passed++;
   endtask

   task automatic test_basic();
      model_run(ABC, 12'h010, '0, '0, '0, -1, 12);
      drive_txn(ABC, 12'h010, '0, '0, '0, -1, 12);
      for (int c = 0; c < 12; c++) begin
         total++;
         if (obs[c] !== expv[c]) $display("FAIL basic cyc%0d got %h want %h", c, obs[c], expv[c]);
         else passed++;
      end
   endtask

   task automatic test_stall();
      logic [MAXC-1:0] st = '0;
      int wc_cyc = -1;
      st[3] = 1'b1; st[4] = 1'b1; st[5] = 1'b1;
      model_run(ABC, 12'h010, '0, '0, st, -1, 15);
      drive_txn(ABC, 12'h010, '0, '0, st, -1, 15);
      for (int c = 0; c < 15; c++) begin
         total++;
         if (obs[c] !== expv[c]) $display("FAIL stall cyc%0d got %h want %h", c, obs[c], expv[c]);
         else passed++;
         if (obs[c][45] && wc_cyc < 0) wc_cyc = c;
      end
      total++;
      if (wc_cyc !== 12) $display("FAIL stall_complete_cycle got %0d want 12", wc_cyc);
      else passed++;
   endtask

   task automatic test_wrap();
      logic [255:0] d = rand_digest();
      model_run(d, 12'hFFE, '0, '0, '0, -1, 12);
      drive_txn(d, 12'hFFE, '0, '0, '0, -1, 12);
      for (int c = 0; c < 12; c++) begin
         total++;
         if (obs[c] !== expv[c]) $display("FAIL wrap cyc%0d got %h want %h", c, obs[c], expv[c]);
         else passed++;
      end
   endtask

   task automatic test_ignored_pulse();
      logic [11:0] b = 12'($urandom);
      int writes = 0;
      model_run(ABC, b, ~ABC, ~b, '0, 4, 13);
      drive_txn(ABC, b, ~ABC, ~b, '0, 4, 13);
      for (int c = 0; c < 13; c++) begin
         total++;
         if (obs[c] !== expv[c]) $display("FAIL ignored_pulse cyc%0d got %h want %h", c, obs[c], expv[c]);
         else passed++;
         if (obs[c][44]) writes++;
      end
      total++;
      if (writes !== 8) $display("FAIL ignored_pulse_write_count got %0d want 8", writes);
      else passed++;
   endtask

   task automatic test_back_to_back();
      logic [255:0] d2 = rand_digest();
      logic [11:0]  b2 = 12'($urandom);
      model_run(ABC, 12'h010, d2, b2, '0, 10, 22);
      drive_txn(ABC, 12'h010, d2, b2, '0, 10, 22);
      for (int c = 0; c < 22; c++) begin
         total++;
         if (obs[c] !== expv[c]) $display("FAIL back_to_back cyc%0d got %h want %h", c, obs[c], expv[c]);
         else passed++;
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 6; it++) begin
         logic [255:0] d1 = rand_digest();
         logic [255:0] d2 = rand_digest();
         logic [11:0]  b1 = 12'($urandom);
         logic [11:0]  b2 = 12'($urandom);
         logic [MAXC-1:0] st = '0;
         int pulse2 = int'($urandom_range(1, 30));
         for (int c = 1; c < 60; c++) st[c] = ($urandom_range(0, 3) == 0);
         model_run(d1, b1, d2, b2, st, pulse2, 60);
         drive_txn(d1, b1, d2, b2, st, pulse2, 60);
         for (int c = 0; c < 60; c++) begin
            total++;
            if (obs[c] !== expv[c])
               $display("FAIL random it%0d cyc%0d got %h want %h", it, c, obs[c], expv[c]);
            else passed++;
         end
      end
   endtask

   task automatic test_reset_abort();
      logic [255:0] d = rand_digest();
      logic [11:0]  b = 12'($urandom);
      int stray = 0;
      digest_valid = 1'b1; digest = ABC; base_address = 12'h020; mem_ready = 1'b1;
      @(posedge clock); #1;
      digest_valid = 1'b0;
      repeat (4) begin @(posedge clock); #1; end
      total++;
      if (mem_write_enable !== 1'b1) $display("FAIL abort_in_progress got %b want 1", mem_write_enable);
      else passed++;
      reset = 1'b0;
      #1;
      total++;
      if ({busy, write_complete, mem_write_enable, mem_address, mem_write_data} !== 47'h0)
         $display("FAIL abort_outputs got %h want 0",
                  {busy, write_complete, mem_write_enable, mem_address, mem_write_data});
      else passed++;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clock);
         if (mem_write_enable || write_complete || busy) stray++;
         @(posedge clock); #1;
      end
      total++;
      if (stray !== 0) $display("FAIL abort_stray_activity got %0d want 0", stray);
      else passed++;
      model_run(d, b, '0, '0, '0, -1, 12);
      drive_txn(d, b, '0, '0, '0, -1, 12);
      for (int c = 0; c < 12; c++) begin
         total++;
         if (obs[c] !== expv[c]) $display("FAIL after_abort cyc%0d got %h want %h", c, obs[c], expv[c]);
         else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_wrap();
      test_ignored_pulse();
      test_back_to_back();
      test_random();
      test_reset_abort();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/sha256_digest_writer.md
# sha256_digest_writer

Write-side counterpart to the message-word read path: takes the final 256-bit SHA-256 digest from the compression core and writes it as eight 32-bit words into the output SRAM. It then raises a one-cycle `write_complete` flag, the write-direction mirror of the core's `read_complete`. It sits between the hash-state registers and the output memory port.

## Interface
Parameters:
- `ADDR_WIDTH`, 12: output memory address width.
- `WORD_WIDTH`, 32: memory data width; fixed to the SHA-256 word size.

Ports:
- `clock`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `digest_valid`  in  1  one-cycle pulse; `digest` and `base_address` are valid in this cycle.
- `digest`  in  256  H0..H7, with H0 in bits [255:224].
- `base_address`  in  ADDR_WIDTH  word address at which H0 is written.
- `mem_ready`  in  1  memory accepts the write presented in this cycle.
- `mem_write_enable`  out  1  write request.
- `mem_address`  out  ADDR_WIDTH  write address.
- `mem_write_data`  out  WORD_WIDTH  write data.
- `busy`  out  1  high whenever state ≠ IDLE.
- `write_complete`  out  1  one-cycle pulse after the eighth write is accepted.

## Operation
- **States:** IDLE, WRITE, DONE. A 3-bit word index runs 0..7.
- **IDLE:**
  - When `digest_valid`=1, capture `digest` and `base_address` into internal registers, set index=0, and go to WRITE.
  - All other inputs are ignored.
- **WRITE:**
  - Drive `mem_write_enable`=1, `mem_address`=base+index, and `mem_write_data`=word[index].
  - word[i] = digest bits [255-32i : 224-32i], so words are big-endian H0 first.
- **Write acceptance:**
  - A write is accepted in a cycle where `mem_write_enable` && `mem_ready` are both 1.
  - On acceptance the index increments, and the next word's address and data are presented in the following cycle.
  - When index 7 is accepted, go to DONE and drop `mem_write_enable` in the next cycle.
- **Stall:** while `mem_ready`=0, address, data and enable hold their values exactly. Any stall length is allowed.
- **DONE:** `write_complete`=1 for exactly one cycle, then return to IDLE.
- **digest_valid outside IDLE** (WRITE or DONE) is ignored. The captured digest is not overwritten and no error is flagged.
- **Address arithmetic:** base+index is computed modulo 2^ADDR_WIDTH, so a base of 0xFFC wraps to 0x000..0x003.
- **Reset values:** state=IDLE, index=0, and every output is 0 (`mem_write_enable`, `mem_address`, `mem_write_data`, `busy`, `write_complete`).
- **Reset mid-transfer:** abort immediately. No further writes and no `write_complete` for the aborted digest.

## Timing
- All outputs are registered; there is no combinational path from an input to an output.
- `digest_valid` in cycle 0 → first write presented in cycle 1.
- With `mem_ready` held at 1:
  - writes are presented in cycles 1..8;
  - `write_complete` and `busy` are both 1 in cycle 9;
  - state is IDLE in cycle 10, which is the earliest cycle a new `digest_valid` is accepted.
- Each stall cycle adds exactly one cycle to the sequence.
- `busy` rises in cycle 1 and falls in the cycle after `write_complete`.

## Structure
- Shared package `sha256_pkg` holds:
  - `DIGEST_WIDTH`=256, `WORD_WIDTH`=32, `NUM_DIGEST_WORDS`=8;
  - the writer state enum (IDLE, WRITE, DONE).
- No sub-module is needed. The word select is an inline 8:1 mux on the captured digest, feeding the data register.

## Test plan
Test vector is the SHA-256 digest of "abc": ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- **Basic:** "abc" digest, base=0x010, `mem_ready`=1 → addresses 0x010..0x017 with data ba7816bf..f20015ad in cycles 1..8; `write_complete` in cycle 9; `busy` low in cycle 10.
- **Stall:** `mem_ready`=0 for cycles 3–5 → address 0x012 and data 414140de held for 4 cycles; `write_complete` in cycle 12.
- **Wrap:** base=0xFFE → addresses FFE, FFF, 000..005 in order.
- **Ignored pulse:** second `digest_valid` with a different digest in cycle 4 → written words unchanged and exactly 8 writes.
- **Reset abort:** `reset` low during cycle 5 → all outputs 0 immediately and no `write_complete`. A new digest after reset completes normally.
- **Back-to-back:** second `digest_valid` in cycle 10 → its first write in cycle 11, with no gap or loss.
